noc_vc_input_buffer: RTL and testbench

//  Per-virtual-channel input buffer at each torus router input port; consumes common_pkg defaults.
//  - Stores incoming flits in one circular FIFO per VC.
//  - Presents one head flit downstream, chosen by round-robin arbitration over non-empty VCs.
//  - Returns one credit pulse upstream per dequeued flit.

---
 rtl/noc_vc_input_buffer.sv | 161 ++++++++++++++++
 tb/tb_noc_vc_input_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_input_buffer.sv
// noc_vc_input_buffer
//   Per-virtual-channel input buffer for a torus router input port. Each VC owns a
//   circular FIFO. The head flits of the non-empty VCs are arbitrated round-robin
//   onto a single downstream port. A registered one-cycle credit pulse is returned
//   upstream for every flit that is dequeued.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_vc/   credit-gated flit input; in_vc is one-hot and there is no ready
//   in_addr/in_data
//   out_valid/out_ready/out_vc/out_addr/out_data
//                     head flit of the granted VC; a transfer is out_valid & out_ready
//   credit_o          per-VC credit pulse, one cycle after each transfer
//   err_o             sticky flag for an overflow or an illegal in_vc
module noc_vc_input_buffer #(
  parameter int unsigned D_W        = 32,
  parameter int unsigned A_W        = 4,
  parameter int unsigned VC_W       = 3,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [VC_W-1:0] in_vc,
  input  logic [A_W-1:0]  in_addr,
  input  logic [D_W-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VC_W-1:0] out_vc,
  output logic [A_W-1:0]  out_addr,
  output logic [D_W-1:0]  out_data,
  output logic [VC_W-1:0] credit_o,
  output logic            err_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned RW = (VC_W > 1) ? $clog2(VC_W) : 1;
  localparam int unsigned EW = A_W + D_W;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [RW-1:0] idx_t;

  logic [EW-1:0]   mem_q [VC_W][FIFO_DEPTH];
  ptr_t            wr_ptr_q [VC_W];
  ptr_t            wr_ptr_d [VC_W];
  ptr_t            rd_ptr_q [VC_W];
  ptr_t            rd_ptr_d [VC_W];
  idx_t            rr_ptr_q, rr_ptr_d;
  idx_t            sel_q, sel_d;
  logic            lock_q, lock_d;
  logic [VC_W-1:0] credit_q, credit_d;
  logic            err_q, err_d;

  logic [VC_W-1:0] empty, full;
  logic            any_valid, xfer;
  idx_t            grant;
  logic            in_onehot;
  idx_t            in_idx;
  logic            wr_en;
  logic [EW-1:0]   head;

  // Pointers wrap modulo FIFO_DEPTH, which need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    for (int unsigned v = 0; v < VC_W; v++) begin
      empty[v] = (wr_ptr_q[v] == rd_ptr_q[v]);
      full[v]  = (ptr_inc(wr_ptr_q[v]) == rd_ptr_q[v]);
    end
  end

  assign any_valid = ~&empty;

  // While a presented flit waits for out_ready the grant is frozen in sel_q;
  // otherwise scan from rr_ptr for the first non-empty VC.
  always_comb begin : p_arb
    logic        found;
    int unsigned idx;
    found = 1'b0;
    idx   = 0;
    grant = '0;
    if (lock_q) begin
      grant = sel_q;
    end else begin
      for (int unsigned k = 0; k < VC_W; k++) begin
        idx = (int'(rr_ptr_q) + k) % VC_W;
        if (!found && !empty[idx]) begin
          grant = idx_t'(idx);
          found = 1'b1;
        end
      end
    end
  end

  assign head      = mem_q[grant][rd_ptr_q[grant]];
  assign out_valid = any_valid;
  assign out_vc    = any_valid ? (VC_W'(1) << grant) : '0;
  assign out_addr  = any_valid ? head[EW-1:D_W] : '0;
  assign out_data  = any_valid ? head[D_W-1:0] : '0;
  assign credit_o  = credit_q;
  assign err_o     = err_q;

  assign xfer = any_valid & out_ready;

  always_comb begin
    in_idx = '0;
    for (int unsigned v = 0; v < VC_W; v++) begin
      if (in_vc[v]) in_idx = idx_t'(v);
    end
  end

  assign in_onehot = $onehot(in_vc);
  // Fullness is judged on pre-edge state, so a same-cycle dequeue does not rescue it.
  assign wr_en     = in_valid & in_onehot & ~full[in_idx];

  always_comb begin
    for (int unsigned v = 0; v < VC_W; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v];
      rd_ptr_d[v] = rd_ptr_q[v];
      if (wr_en && (in_idx == idx_t'(v))) wr_ptr_d[v] = ptr_inc(wr_ptr_q[v]);
      if (xfer && (grant == idx_t'(v)))   rd_ptr_d[v] = ptr_inc(rd_ptr_q[v]);
    end
    err_d    = err_q | (in_valid & (~in_onehot | full[in_idx]));
    credit_d = xfer ? (VC_W'(1) << grant) : '0;
    lock_d   = any_valid & ~out_ready;
    sel_d    = grant;
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = (grant == idx_t'(VC_W - 1)) ? '0 : grant + idx_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned v = 0; v < VC_W; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
      end
      rr_ptr_q <= '0;
      sel_q    <= '0;
      lock_q   <= 1'b0;
      credit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < VC_W; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
      end
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      lock_q   <= lock_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  // Flit storage needs no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[in_idx][wr_ptr_q[in_idx]] <= {in_addr, in_data};
  end

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
module tb_noc_vc_input_buffer;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int VW = 3;
  localparam int FD = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [VW-1:0] in_vc;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_vc;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [VW-1:0] credit_o;
  logic          err_o;

  always #5 clk = ~clk;

  noc_vc_input_buffer #(
    .D_W       (DW),
    .A_W       (AW),
    .VC_W      (VW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_vc    (in_vc),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_vc   (out_vc),
    .out_addr (out_addr),
    .out_data (out_data),
    .credit_o (credit_o),
    .err_o    (err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue of {addr,data} per VC plus the arbitration state.
  logic [AW+DW-1:0] mq [VW][$];
  int               m_rr;
  bit               m_locked;
  int               m_lvc;
  bit               m_err;
  logic [VW-1:0]    m_cred;

  task automatic model_reset();
    for (int v = 0; v < VW; v++) mq[v].delete();
    m_rr = 0; m_locked = 0; m_lvc = 0; m_err = 0; m_cred = '0;
  endtask

  function automatic int m_sel();
    if (m_locked) return m_lvc;
    for (int k = 0; k < VW; k++) begin
      if (mq[(m_rr + k) % VW].size() > 0) return (m_rr + k) % VW;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    int s;
    logic [AW+DW-1:0] h;
    s = m_sel();
    if (s < 0) begin
      chk("out_valid", 64'(out_valid), 64'd0);
      chk("out_vc_idle", 64'(out_vc), 64'd0);
      chk("out_addr_idle", 64'(out_addr), 64'd0);
      chk("out_data_idle", 64'(out_data), 64'd0);
    end else begin
      h = mq[s][0];
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_vc", 64'(out_vc), 64'(1 << s));
      chk("out_addr", 64'(out_addr), 64'(h[AW+DW-1:DW]));
      chk("out_data", 64'(out_data), 64'(h[DW-1:0]));
    end
    chk("credit_o", 64'(credit_o), 64'(m_cred));
    chk("err_o", 64'(err_o), 64'(m_err));
  endtask

  task automatic model_step();
    int s;
    int wv;
    s  = m_sel();
    wv = -1;
    if (in_valid) begin
      if (!$onehot(in_vc)) m_err = 1;
      else begin
        for (int v = 0; v < VW; v++) if (in_vc[v]) wv = v;
        if (mq[wv].size() == FD - 1) begin
          m_err = 1;
          wv = -1;
        end
      end
    end
    if (s >= 0 && out_ready) begin
      void'(mq[s].pop_front());
      m_cred   = VW'(1 << s);
      m_rr     = (s + 1) % VW;
      m_locked = 0;
    end else begin
      m_cred = '0;
      if (s >= 0) begin
        m_locked = 1;
        m_lvc    = s;
      end
    end
    if (wv >= 0) mq[wv].push_back({in_addr, in_data});
  endtask

  // One model-checked clock cycle; entered and left at posedge+1.
  task automatic cycle(input logic v, input logic [VW-1:0] vc, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rdy);
    in_valid = v; in_vc = vc; in_addr = a; in_data = d; out_ready = rdy;
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_vc = '0; in_addr = '0; in_data = '0; out_ready = 0;
    #2 rst_n = 0;
    #13 rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          iv;
    logic [VW-1:0] ivc;
    logic [AW-1:0] ia;
    logic [DW-1:0] id;
    logic          rdy;
    logic          ev;
    logic [VW-1:0] evc;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [VW-1:0] ecr;
    logic          eerr;
  } vec_t;

  vec_t tbl [9];
  int   cred_cnt;
  logic [VW-1:0] rvc;

  initial begin
    // Single flit on VC1, its credit, then illegal VC selects.
    tbl[0] = '{1'b0, 3'b000, 4'h0, 32'h0,        1'b1, 1'b0, 3'b000, 4'h0, 32'h0,        3'b000, 1'b0};
    tbl[1] = '{1'b1, 3'b010, 4'h5, 32'hDEADBEEF, 1'b1, 1'b0, 3'b000, 4'h0, 32'h0,        3'b000, 1'b0};
    tbl[2] = '{1'b0, 3'b000, 4'h0, 32'h0,        1'b1, 1'b1, 3'b010, 4'h5, 32'hDEADBEEF, 3'b000, 1'b0};
    tbl[3] = '{1'b0, 3'b000, 4'h0, 32'h0,        1'b1, 1'b0, 3'b000, 4'h0, 32'h0,        3'b010, 1'b0};
    tbl[4] = '{1'b0, 3'b000, 4'h0, 32'h0,        1'b1, 1'b0, 3'b000, 4'h0, 32'h0,        3'b000, 1'b0};
    tbl[5] = '{1'b1, 3'b011, 4'h3, 32'h1234,     1'b1, 1'b0, 3'b000, 4'h0, 32'h0,        3'b000, 1'b0};
    tbl[6] = '{1'b0, 3'b000, 4'h0, 32'h0,        1'b1, 1'b0, 3'b000, 4'h0, 32'h0,        3'b000, 1'b1};
    tbl[7] = '{1'b1, 3'b000, 4'h1, 32'h1,        1'b1, 1'b0, 3'b000, 4'h0, 32'h0,        3'b000, 1'b1};
    tbl[8] = '{1'b0, 3'b000, 4'h0, 32'h0,        1'b1, 1'b0, 3'b000, 4'h0, 32'h0,        3'b000, 1'b1};

    rst_n = 1;
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 10; i++) cycle(0, '0, '0, '0, 1);

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      in_valid = tbl[i].iv; in_vc = tbl[i].ivc; in_addr = tbl[i].ia;
      in_data = tbl[i].id; out_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_vc", i), 64'(out_vc), 64'(tbl[i].evc));
      chk($sformatf("tbl%0d_addr", i), 64'(out_addr), 64'(tbl[i].ea));
      chk($sformatf("tbl%0d_data", i), 64'(out_data), 64'(tbl[i].ed));
      chk($sformatf("tbl%0d_credit", i), 64'(credit_o), 64'(tbl[i].ecr));
      chk($sformatf("tbl%0d_err", i), 64'(err_o), 64'(tbl[i].eerr));
      @(posedge clk);
      #1;
    end

    // Overflow VC0: 31 flits fit, the 32nd is dropped, then drain in order.
    do_reset();
    for (int i = 0; i < FD; i++) cycle(1, 3'b001, AW'(i), DW'(32'hA000 + i), 0);
    cycle(0, '0, '0, '0, 0);
    chk("overflow_err", 64'(err_o), 64'd1);
    cred_cnt = 0;
    for (int i = 0; i < FD + 2; i++) begin
      cycle(0, '0, '0, '0, 1);
      if (credit_o[0]) cred_cnt++;
    end
    chk("vc0_credit_count", 64'(cred_cnt), 64'(FD - 1));

    // Round-robin over three VCs, then refill VC0 and VC2.
    do_reset();
    cycle(1, 3'b001, 4'h1, 32'h10, 0);
    cycle(1, 3'b010, 4'h2, 32'h20, 0);
    cycle(1, 3'b100, 4'h3, 32'h30, 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, '0, 1);
    cycle(1, 3'b100, 4'h6, 32'h62, 0);
    cycle(1, 3'b001, 4'h7, 32'h70, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, '0, 1);

    // Stalled VC2 head while VC0 fills, then VC0 follows.
    cycle(1, 3'b100, 4'h9, 32'h900D, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 3'b001, AW'(i), DW'(32'hB0 + i), 0);
      chk("stall_vc", 64'(out_vc), 64'd4);
      chk("stall_data", 64'(out_data), 64'h900D);
    end
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, '0, 1);

    // Illegal select mid-traffic, then asynchronous reset.
    cycle(1, 3'b011, 4'h1, 32'h1, 1);
    cycle(1, 3'b010, 4'h2, 32'h2, 0);
    cycle(1, 3'b010, 4'h3, 32'h3, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_vc", 64'(out_vc), 64'd0);
    chk("rst_addr", 64'(out_addr), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_credit", 64'(credit_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    do_reset();

    // Randomized traffic with alternating backpressure phases.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) rvc = VW'($urandom_range(0, 7));
      else rvc = VW'(1 << $urandom_range(0, VW - 1));
      cycle(logic'($urandom_range(0, 99) < 70), rvc, AW'($urandom), DW'($urandom),
            logic'($urandom_range(0, 99) < (((i / 150) % 2 == 1) ? 25 : 90)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
